// File: rtl/VX_gpu_pkg.sv
// Shared GPU types: tensor commit beat layout and the beat-counter width helper.
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package VX_gpu_pkg;

    localparam int NW_WIDTH   = (`NUM_WARPS > 1) ? $clog2(`NUM_WARPS) : 1;
    localparam int UUID_WIDTH = 44;
    localparam int XLEN       = 32;
    localparam int NR_BITS    = 6;
    localparam int PID_WIDTH  = 1;

    // Payload forwarded to the register file; also produced by the tensor core.
    typedef struct packed {
        logic [UUID_WIDTH-1:0]                 uuid;
        logic [NW_WIDTH-1:0]                   wid;
        logic [`NUM_THREADS-1:0]               tmask;
        logic [XLEN-1:0]                       PC;
        logic [NR_BITS-1:0]                    rd;
        logic [`NUM_THREADS-1:0][XLEN-1:0]     data;
        logic                                  sop;
        logic                                  eop;
    } tensor_beat_t;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]                 uuid;
        logic [NW_WIDTH-1:0]                   wid;
        logic [`NUM_THREADS-1:0]               tmask;
        logic [XLEN-1:0]                       PC;
        logic                                  wb;
        logic [NR_BITS-1:0]                    rd;
        logic [`NUM_THREADS-1:0][XLEN-1:0]     data;
        logic                                  tensor;
        logic [PID_WIDTH-1:0]                  pid;
        logic                                  sop;
        logic                                  eop;
    } commit_data_t;

    // Counter must hold 0..max_beats inclusive.
    function automatic int tensor_cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/VX_commit_if.sv
// Commit stream from an execution unit towards the commit stage.
interface VX_commit_if;
    logic                     valid;
    VX_gpu_pkg::commit_data_t data;
    logic                     ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/VX_writeback_if.sv
// Register-file writeback port; the consumer's ready travels separately.
interface VX_writeback_if;
    logic                     valid;
    VX_gpu_pkg::tensor_beat_t data;

    modport master (output valid, output data);
    modport slave  (input valid, input data);
endinterface

// File: rtl/VX_pipe_register.sv
// Enabled pipeline register with synchronous clear.
module VX_pipe_register #(
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out
);
    logic [DATAW-1:0] data_r;

    // Capture on enable, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {DATAW{1'b0}};
        end else if (enable) begin
            data_r <= data_in;
        end
    end

    assign data_out = data_r;
endmodule

// File: rtl/VX_tensor_warp_tracker.sv
// Per-warp progress of one multi-beat tensor instruction: open flag, beat count, uuid.
module VX_tensor_warp_tracker
    import VX_gpu_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int CNTW      = tensor_cnt_width(MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  beat_fire,
    input  logic [UUID_WIDTH-1:0] beat_uuid,
    input  logic                  beat_eop,
    output logic                  open,
    output logic                  done,
    output logic [CNTW-1:0]       beats,
    output logic [UUID_WIDTH-1:0] inst_uuid,
    output logic                  err
);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_BEATS);

    logic                  open_r;
    logic [CNTW-1:0]       cnt_r;
    logic [UUID_WIDTH-1:0] uuid_r;
    logic [CNTW-1:0]       cnt_next_s;
    logic                  mismatch_s;
    logic                  overflow_s;

    // Updated count and protocol checks for a beat landing on this warp.
    always_comb begin
        cnt_next_s = CNTW'(1);
        mismatch_s = 1'b0;
        overflow_s = 1'b0;
        if (open_r) begin
            mismatch_s = (beat_uuid != uuid_r);
            overflow_s = (cnt_r == MAX_CNT) && !beat_eop;
            cnt_next_s = (cnt_r == MAX_CNT) ? MAX_CNT : cnt_r + CNTW'(1);
        end else begin
            cnt_next_s = CNTW'(1);
        end
    end

    // Instruction state; the first beat of an instruction captures its uuid.
    always_ff @(posedge clk) begin
        if (reset) begin
            open_r <= 1'b0;
            cnt_r  <= {CNTW{1'b0}};
            uuid_r <= {UUID_WIDTH{1'b0}};
        end else if (beat_fire) begin
            open_r <= !beat_eop;
            cnt_r  <= beat_eop ? {CNTW{1'b0}} : cnt_next_s;
            if (!open_r) begin
                uuid_r <= beat_uuid;
            end
        end
    end

    assign open      = open_r;
    assign done      = beat_fire && beat_eop;
    assign beats     = cnt_next_s;
    assign inst_uuid = open_r ? uuid_r : beat_uuid;
    assign err       = beat_fire && (mismatch_s || overflow_s);
endmodule

// File: rtl/vx_tensor_commit_collector.sv
// Receives tensor commit beats, forwards writebacks through a one-entry stage,
// tracks per-warp instruction progress and pulses retire on each end of packet.
module vx_tensor_commit_collector
    import VX_gpu_pkg::*;
#(
    parameter int NUM_WARPS = `NUM_WARPS,
    parameter int NUM_LANES = `NUM_THREADS,
    parameter int MAX_BEATS = 4,
    parameter int CNTW      = tensor_cnt_width(MAX_BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    VX_commit_if.slave            commit_if,
    VX_writeback_if.master        writeback_if,
    input  logic                  writeback_ready,
    output logic                  retire_valid,
    output logic [NW_WIDTH-1:0]   retire_wid,
    output logic [UUID_WIDTH-1:0] retire_uuid,
    output logic [CNTW-1:0]       retire_beats,
    output logic [NUM_WARPS-1:0]  warp_busy,
    output logic                  proto_error
);
    localparam int STAGE_W = 1 + $bits(tensor_beat_t);

    logic                  ready_s;
    logic                  fire_s;
    logic                  fill_s;
    logic                  stage_en_s;
    logic [NUM_LANES-1:0]  lane_mask_s;
    tensor_beat_t          beat_s;
    logic [STAGE_W-1:0]    stage_q_s;
    logic                  wb_valid_r;
    tensor_beat_t          wb_beat_r;

    logic [NUM_WARPS-1:0]  trk_fire_s;
    logic [NUM_WARPS-1:0]  trk_done_s;
    logic [NUM_WARPS-1:0]  trk_err_s;
    logic [NUM_WARPS-1:0]  trk_open_s;
    logic [CNTW-1:0]       trk_beats_s [NUM_WARPS];
    logic [UUID_WIDTH-1:0] trk_uuid_s  [NUM_WARPS];

    logic                  done_any_s;
    logic                  err_any_s;
    logic [CNTW-1:0]       sel_beats_s;
    logic [UUID_WIDTH-1:0] sel_uuid_s;

    logic                  retire_valid_r;
    logic [NW_WIDTH-1:0]   retire_wid_r;
    logic [UUID_WIDTH-1:0] retire_uuid_r;
    logic [CNTW-1:0]       retire_beats_r;
    logic                  proto_error_r;
    logic                  unused_s;

    // Stall only while a held writeback is not being drained this cycle.
    assign ready_s         = !(wb_valid_r && !writeback_ready);
    assign commit_if.ready = ready_s;
    assign fire_s          = commit_if.valid && ready_s;
    assign fill_s          = fire_s && commit_if.data.wb;
    assign stage_en_s      = fill_s || writeback_ready;
    assign lane_mask_s     = commit_if.data.tmask;
    assign unused_s        = &{1'b0, commit_if.data.tensor, commit_if.data.pid};

    // Repack the incoming beat into the writeback payload.
    always_comb begin
        beat_s       = '0;
        beat_s.uuid  = commit_if.data.uuid;
        beat_s.wid   = commit_if.data.wid;
        beat_s.tmask = lane_mask_s;
        beat_s.PC    = commit_if.data.PC;
        beat_s.rd    = commit_if.data.rd;
        beat_s.data  = commit_if.data.data;
        beat_s.sop   = commit_if.data.sop;
        beat_s.eop   = commit_if.data.eop;
    end

    // A drain without a fill loads valid=0, which empties the stage.
    VX_pipe_register #(
        .DATAW (STAGE_W)
    ) wb_stage (
        .clk      (clk),
        .reset    (reset),
        .enable   (stage_en_s),
        .data_in  ({fill_s, beat_s}),
        .data_out (stage_q_s)
    );

    assign {wb_valid_r, wb_beat_r} = stage_q_s;
    assign writeback_if.valid      = wb_valid_r;
    assign writeback_if.data       = wb_beat_r;

    for (genvar w = 0; w < NUM_WARPS; ++w) begin : g_warp
        assign trk_fire_s[w] = fire_s && (commit_if.data.wid == NW_WIDTH'(w));

        VX_tensor_warp_tracker #(
            .MAX_BEATS (MAX_BEATS),
            .CNTW      (CNTW)
        ) tracker (
            .clk       (clk),
            .reset     (reset),
            .beat_fire (trk_fire_s[w]),
            .beat_uuid (commit_if.data.uuid),
            .beat_eop  (commit_if.data.eop),
            .open      (trk_open_s[w]),
            .done      (trk_done_s[w]),
            .beats     (trk_beats_s[w]),
            .inst_uuid (trk_uuid_s[w]),
            .err       (trk_err_s[w])
        );
    end

    // At most one warp fires per cycle, so masked OR selects its results.
    always_comb begin
        done_any_s  = |trk_done_s;
        err_any_s   = |trk_err_s;
        sel_beats_s = {CNTW{1'b0}};
        sel_uuid_s  = {UUID_WIDTH{1'b0}};
        for (int w = 0; w < NUM_WARPS; w++) begin
            sel_beats_s = sel_beats_s | (trk_beats_s[w] & {CNTW{trk_fire_s[w]}});
            sel_uuid_s  = sel_uuid_s | (trk_uuid_s[w] & {UUID_WIDTH{trk_fire_s[w]}});
        end
    end

    // Retire pulse, its descriptor, and the sticky protocol error.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid_r <= 1'b0;
            retire_wid_r   <= {NW_WIDTH{1'b0}};
            retire_uuid_r  <= {UUID_WIDTH{1'b0}};
            retire_beats_r <= {CNTW{1'b0}};
            proto_error_r  <= 1'b0;
        end else begin
            retire_valid_r <= done_any_s;
            if (done_any_s) begin
                retire_wid_r   <= commit_if.data.wid;
                retire_uuid_r  <= sel_uuid_s;
                retire_beats_r <= sel_beats_s;
            end
            proto_error_r  <= proto_error_r | err_any_s;
        end
    end

    assign retire_valid = retire_valid_r;
    assign retire_wid   = retire_wid_r;
    assign retire_uuid  = retire_uuid_r;
    assign retire_beats = retire_beats_r;
    assign warp_busy    = trk_open_s;
    assign proto_error  = proto_error_r;
endmodule

// File: tb/tb_vx_tensor_commit_collector.sv
// Directed self-checking bench for vx_tensor_commit_collector.
module tb_vx_tensor_commit_collector;
    import VX_gpu_pkg::*;

    localparam int NWARPS = `NUM_WARPS;
    localparam int CW     = tensor_cnt_width(4);

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  writeback_ready;
    logic                  retire_valid;
    logic [NW_WIDTH-1:0]   retire_wid;
    logic [UUID_WIDTH-1:0] retire_uuid;
    logic [CW-1:0]         retire_beats;
    logic [NWARPS-1:0]     warp_busy;
    logic                  proto_error;

    VX_commit_if    commit_if();
    VX_writeback_if writeback_if();

    int n_checks = 0;
    int n_fail   = 0;

    vx_tensor_commit_collector #(
        .MAX_BEATS (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .commit_if       (commit_if),
        .writeback_if    (writeback_if),
        .writeback_ready (writeback_ready),
        .retire_valid    (retire_valid),
        .retire_wid      (retire_wid),
        .retire_uuid     (retire_uuid),
        .retire_beats    (retire_beats),
        .warp_busy       (warp_busy),
        .proto_error     (proto_error)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int wid, input int uuid, input int rd, input bit wb, input bit eop);
        commit_if.valid     = 1'b1;
        commit_if.data.wid  = NW_WIDTH'(wid);
        commit_if.data.uuid = UUID_WIDTH'(uuid);
        commit_if.data.rd   = NR_BITS'(rd);
        commit_if.data.wb   = wb;
        commit_if.data.eop  = eop;
        commit_if.data.sop  = 1'b1;
        commit_if.data.PC   = 32'h1000 + 32'(rd);
        for (int l = 0; l < `NUM_THREADS; l++) begin
            commit_if.data.data[l] = 32'hA000 + 32'(rd);
        end
    endtask

    task automatic send(input int wid, input int uuid, input int rd, input bit wb, input bit eop);
        drive_beat(wid, uuid, rd, wb, eop);
        tick();
        commit_if.valid = 1'b0;
    endtask

    task automatic do_reset();
        commit_if.valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  exp_wbv;
        int  nxt;
        int  consumed;
        bit  exp_rdy;
        bit  fire;

        commit_if.valid = 1'b0;
        commit_if.data  = '0;
        writeback_ready = 1'b1;
        do_reset();

        // Reset state
        check_value("rst_wb_valid", 64'(writeback_if.valid), 64'd0);
        check_value("rst_retire_valid", 64'(retire_valid), 64'd0);
        check_value("rst_retire_wid", 64'(retire_wid), 64'd0);
        check_value("rst_retire_uuid", 64'(retire_uuid), 64'd0);
        check_value("rst_retire_beats", 64'(retire_beats), 64'd0);
        check_value("rst_busy", 64'(warp_busy), 64'd0);
        check_value("rst_proto", 64'(proto_error), 64'd0);
        check_value("rst_ready", 64'(commit_if.ready), 64'd1);

        // 3-beat instruction, warp 0, uuid 7
        send(0, 7, 33, 1'b0, 1'b0);
        check_value("t1_b1_wbv", 64'(writeback_if.valid), 64'd0);
        check_value("t1_b1_busy", 64'(warp_busy), 64'd1);
        check_value("t1_b1_ret", 64'(retire_valid), 64'd0);
        send(0, 7, 34, 1'b0, 1'b0);
        check_value("t1_b2_wbv", 64'(writeback_if.valid), 64'd0);
        check_value("t1_b2_busy", 64'(warp_busy), 64'd1);
        send(0, 7, 35, 1'b1, 1'b1);
        check_value("t1_wbv", 64'(writeback_if.valid), 64'd1);
        check_value("t1_wb_rd", 64'(writeback_if.data.rd), 64'd35);
        check_value("t1_wb_eop", 64'(writeback_if.data.eop), 64'd1);
        check_value("t1_wb_data", 64'(writeback_if.data.data[0]), 64'hA023);
        check_value("t1_wb_uuid", 64'(writeback_if.data.uuid), 64'd7);
        check_value("t1_ret", 64'(retire_valid), 64'd1);
        check_value("t1_ret_wid", 64'(retire_wid), 64'd0);
        check_value("t1_ret_uuid", 64'(retire_uuid), 64'd7);
        check_value("t1_ret_beats", 64'(retire_beats), 64'd3);
        check_value("t1_busy_fall", 64'(warp_busy), 64'd0);
        tick();
        check_value("t1_wbv_drain", 64'(writeback_if.valid), 64'd0);
        check_value("t1_ret_pulse", 64'(retire_valid), 64'd0);

        // Back-pressure: warp 2, uuid 20, four wb beats, ready low 5 cycles
        exp_wbv  = 0;
        nxt      = 1;
        consumed = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            writeback_ready = (cyc >= 1 && cyc <= 5) ? 1'b0 : 1'b1;
            if (nxt <= 4) drive_beat(2, 20, nxt, 1'b1, nxt == 4);
            else commit_if.valid = 1'b0;
            #1;
            exp_rdy = !(exp_wbv != 0 && !writeback_ready);
            check_value("bp_ready", 64'(commit_if.ready), 64'(exp_rdy));
            if (exp_wbv != 0 && writeback_ready) begin
                consumed++;
                check_value("bp_wb_order", 64'(writeback_if.data.rd), 64'(consumed));
            end
            fire = (nxt <= 4) && exp_rdy;
            if (fire) begin
                exp_wbv = 1;
                nxt++;
            end else if (writeback_ready) begin
                exp_wbv = 0;
            end
            tick();
            check_value("bp_wb_valid", 64'(writeback_if.valid), 64'(exp_wbv));
            check_value("bp_ret", 64'(retire_valid), 64'(fire && nxt == 5));
            if (fire && nxt == 5) begin
                check_value("bp_ret_beats", 64'(retire_beats), 64'd4);
                check_value("bp_ret_uuid", 64'(retire_uuid), 64'd20);
            end
        end
        check_value("bp_consumed", 64'(consumed), 64'd4);
        commit_if.valid = 1'b0;
        writeback_ready = 1'b1;

        // Interleaved warps 0 and 1
        send(0, 100, 1, 1'b0, 1'b0);
        send(1, 101, 2, 1'b0, 1'b0);
        check_value("il_busy", 64'(warp_busy), 64'd3);
        send(0, 100, 3, 1'b0, 1'b0);
        send(1, 101, 4, 1'b0, 1'b0);
        send(0, 100, 5, 1'b0, 1'b1);
        check_value("il_ret0", 64'(retire_valid), 64'd1);
        check_value("il_ret0_wid", 64'(retire_wid), 64'd0);
        check_value("il_ret0_uuid", 64'(retire_uuid), 64'd100);
        check_value("il_ret0_beats", 64'(retire_beats), 64'd3);
        send(1, 101, 6, 1'b0, 1'b1);
        check_value("il_ret1", 64'(retire_valid), 64'd1);
        check_value("il_ret1_wid", 64'(retire_wid), 64'd1);
        check_value("il_ret1_uuid", 64'(retire_uuid), 64'd101);
        check_value("il_ret1_beats", 64'(retire_beats), 64'd3);
        check_value("il_proto", 64'(proto_error), 64'd0);
        check_value("il_busy_end", 64'(warp_busy), 64'd0);

        // uuid mismatch on warp 0
        send(0, 5, 10, 1'b1, 1'b0);
        check_value("mm_proto_pre", 64'(proto_error), 64'd0);
        send(0, 6, 11, 1'b1, 1'b1);
        check_value("mm_proto", 64'(proto_error), 64'd1);
        check_value("mm_ret", 64'(retire_valid), 64'd1);
        check_value("mm_ret_beats", 64'(retire_beats), 64'd2);
        check_value("mm_ret_uuid", 64'(retire_uuid), 64'd5);
        tick();
        check_value("mm_proto_sticky", 64'(proto_error), 64'd1);
        check_value("mm_ret_pulse", 64'(retire_valid), 64'd0);

        // Overflow: five beats without eop, then eop
        do_reset();
        check_value("ov_proto_clr", 64'(proto_error), 64'd0);
        for (int b = 1; b <= 4; b++) send(3, 9, b, 1'b0, 1'b0);
        check_value("ov_proto_4", 64'(proto_error), 64'd0);
        send(3, 9, 5, 1'b0, 1'b0);
        check_value("ov_proto_5", 64'(proto_error), 64'd1);
        check_value("ov_busy", 64'(warp_busy), 64'd8);
        send(3, 9, 6, 1'b0, 1'b1);
        check_value("ov_ret", 64'(retire_valid), 64'd1);
        check_value("ov_ret_beats", 64'(retire_beats), 64'd4);
        check_value("ov_ret_wid", 64'(retire_wid), 64'd3);

        // Reset mid-instruction
        do_reset();
        send(1, 12, 20, 1'b1, 1'b0);
        send(1, 12, 21, 1'b1, 1'b0);
        check_value("rm_busy_pre", 64'(warp_busy), 64'd2);
        check_value("rm_wbv_pre", 64'(writeback_if.valid), 64'd1);
        do_reset();
        check_value("rm_busy", 64'(warp_busy), 64'd0);
        check_value("rm_wbv", 64'(writeback_if.valid), 64'd0);
        check_value("rm_ret", 64'(retire_valid), 64'd0);
        tick();
        check_value("rm_ret_after", 64'(retire_valid), 64'd0);
        send(1, 13, 22, 1'b0, 1'b0);
        send(1, 13, 23, 1'b0, 1'b0);
        send(1, 13, 24, 1'b1, 1'b1);
        check_value("rm_new_ret", 64'(retire_valid), 64'd1);
        check_value("rm_new_beats", 64'(retire_beats), 64'd3);
        check_value("rm_new_uuid", 64'(retire_uuid), 64'd13);
        check_value("rm_new_proto", 64'(proto_error), 64'd0);
        check_value("rm_new_wb_rd", 64'(writeback_if.data.rd), 64'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
